// File: rtl/ssriscv_instr_encoder.sv
// RV32I instruction encoder: turns a field tuple into a 32-bit word, buffers it in a
// 2-entry FIFO and tags each emitted word with an incrementing target address.
module ssriscv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [2:0]  in_func3,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic        in_arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_sticky,
  output logic [7:0]  err_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 2;

  localparam logic [3:0] K_ALU   = 4'd0;
  localparam logic [3:0] K_ALUI  = 4'd1;
  localparam logic [3:0] K_LOAD  = 4'd2;
  localparam logic [3:0] K_STORE = 4'd3;
  localparam logic [3:0] K_BXX   = 4'd4;
  localparam logic [3:0] K_JAL   = 4'd5;
  localparam logic [3:0] K_JALR  = 4'd6;
  localparam logic [3:0] K_LUI   = 4'd7;
  localparam logic [3:0] K_AUIPC = 4'd8;

  logic [WORD_W-1:0] enc_c;
  logic              legal_c;
  logic              push_c;
  logic              reject_c;
  logic              pop_c;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic [WORD_W-1:0] head_d;
  logic [WORD_W-1:0] addr_d;
  logic              sticky_d;
  logic [7:0]        errcnt_d;

  // Field-to-word encoder, one format per instruction class
  always_comb begin
    enc_c = '0;
    unique case (in_kind)
      K_ALU:   enc_c = {1'b0, in_arith, 5'b0, in_rs2, in_rs1, in_func3, in_rd, 7'b0110011};
      K_ALUI:  begin
        if (in_func3 == 3'b001 || in_func3 == 3'b101)
          enc_c = {1'b0, in_arith, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, 7'b0010011};
        else
          enc_c = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0010011};
      end
      K_LOAD:  enc_c = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0000011};
      K_STORE: enc_c = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], 7'b0100011};
      K_BXX:   enc_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3, in_imm[4:1],
                        in_imm[11], 7'b1100011};
      K_JAL:   enc_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      K_JALR:  enc_c = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      K_LUI:   enc_c = {in_imm[31:12], in_rd, 7'b0110111};
      K_AUIPC: enc_c = {in_imm[31:12], in_rd, 7'b0010111};
      default: enc_c = '0;
    endcase
  end

  // Odd branch/jump offsets are unencodable and are consumed without being stored
  assign legal_c  = (in_kind <= K_AUIPC) &&
                    !(((in_kind == K_BXX) || (in_kind == K_JAL)) && in_imm[0]);
  assign push_c   = in_valid && in_ready && legal_c;
  assign reject_c = in_valid && in_ready && !legal_c;
  assign pop_c    = out_valid && out_ready;

  // Next-state: head word lives in out_instr, second word in tail_q
  always_comb begin
    count_d  = count_q;
    head_d   = out_instr;
    tail_d   = tail_q;
    addr_d   = out_addr;
    sticky_d = err_sticky;
    errcnt_d = err_count;
    if (clr) begin
      count_d  = '0;
      head_d   = '0;
      addr_d   = BASE_ADDR;
      sticky_d = 1'b0;
      errcnt_d = '0;
    end else begin
      if (pop_c) addr_d = out_addr + ADDR_STEP;
      if (reject_c) begin
        sticky_d = 1'b1;
        if (err_count != 8'hFF) errcnt_d = err_count + 8'd1;
      end
      unique case (count_q)
        2'd0: begin
          if (push_c) begin
            head_d  = enc_c;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push_c && pop_c) begin
            head_d = enc_c;
          end else if (push_c) begin
            tail_d  = enc_c;
            count_d = 2'd2;
          end else if (pop_c) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (pop_c) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
      endcase
    end
  end

  // State and registered outputs; in_ready stays low until the first edge out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      tail_q     <= '0;
      out_instr  <= '0;
      out_addr   <= BASE_ADDR;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      count_q    <= count_d;
      tail_q     <= tail_d;
      out_instr  <= head_d;
      out_addr   <= addr_d;
      out_valid  <= (count_d != 2'd0);
      in_ready   <= (count_d != 2'd2);
      err_sticky <= sticky_d;
      err_count  <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_ssriscv_instr_encoder.sv
// Scoreboard bench for ssriscv_instr_encoder: directed scenarios plus randomized tuples
// checked against an arithmetic reference encoder.
module tb_ssriscv_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] STEP = 32'd4;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_func3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_sticky;
  logic [7:0]  err_count;

  logic rnd_ready;
  logic rnd_bit;
  logic fixed_ready;
  assign out_ready = rnd_ready ? rnd_bit : fixed_ready;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   emitted;
  int   push_count;
  int   err_model;

  ssriscv_instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_func3(in_func3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference encoder built from bit positions with shifts and masks
  function automatic logic [31:0] ref_encode(input int kind, input int f3, input int rs1,
                                             input int rs2, input int rd,
                                             input logic [31:0] imm, input int ar);
    logic [31:0] r;
    logic [31:0] regs;
    regs = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
    case (kind)
      0: r = (32'(ar) << 30) | (32'(rs2) << 20) | regs | 32'h33;
      1: if (f3 == 1 || f3 == 5) r = (32'(ar) << 30) | ((imm & 32'h1F) << 20) | regs | 32'h13;
         else r = ((imm & 32'hFFF) << 20) | regs | 32'h13;
      2: r = ((imm & 32'hFFF) << 20) | regs | 32'h03;
      3: r = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
             (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'h23;
      4: r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
             (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 1) << 7) | 32'h63;
      5: r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
      6: r = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
      7: r = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
      default: r = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h17;
    endcase
    return r;
  endfunction

  // Offer a tuple until accepted; the k-th pushed word since flush is expected at BASE+k*STEP
  task automatic send(input int kind, input int f3, input int rs1, input int rs2, input int rd,
                      input logic [31:0] imm, input int ar,
                      input bit has_exp, input logic [31:0] exp_word);
    bit   accepted;
    bit   legal;
    exp_t e;
    in_kind  = 4'(kind);
    in_func3 = 3'(f3);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_rd    = 5'(rd);
    in_imm   = imm;
    in_arith = 1'(ar);
    in_valid = 1'b1;
    accepted = 1'b0;
    legal    = (kind <= 8) && !((kind == 4 || kind == 5) && imm[0]);
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (legal) begin
          e.instr = has_exp ? exp_word : ref_encode(kind, f3, rs1, rs2, rd, imm, ar);
          e.addr  = BASE + STEP * 32'(push_count);
          push_count++;
          q.push_back(e);
        end else if (err_model < 255) begin
          err_model++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    q.delete();
    push_count = 0;
    err_model  = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !clr && out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", out_instr, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_addr", out_addr, e.addr);
          emitted++;
        end
      end
    end
  endtask

  task automatic stimulus();
    int e0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_kind = '0; in_func3 = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_arith = 1'b0;
    rnd_ready = 1'b0; fixed_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_err", {23'd0, err_sticky, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("first_edge_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5 with one-cycle latency
    check("idle_out_valid", 32'(out_valid), 32'd0);
    send(1, 0, 0, 0, 1, 32'd5, 0, 1'b1, 32'h00500093);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    fixed_ready = 1'b1;
    wait_drain();

    // sub x3,x1,x2 then jal x1,8
    do_clr();
    send(0, 0, 1, 2, 3, 32'd0, 1, 1'b1, 32'h402081B3);
    send(5, 0, 0, 0, 1, 32'd8, 0, 1'b1, 32'h008000EF);
    wait_drain();

    // Backpressure: two fill the FIFO, third waits for a pop
    do_clr();
    fixed_ready = 1'b0;
    e0 = emitted;
    send(7, 0, 0, 0, 5, 32'hABCDE000, 0, 1'b0, 32'd0);
    send(3, 2, 4, 6, 0, 32'h0000_07F5, 0, 1'b0, 32'd0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("full_hold_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    fixed_ready = 1'b1;
    send(6, 7, 9, 0, 2, 32'h0000_0804, 0, 1'b0, 32'd0);
    wait_drain();
    check("bp_emitted", 32'(emitted - e0), 32'd3);

    // Rejected tuples then clear
    do_clr();
    send(15, 0, 0, 0, 0, 32'd0, 0, 1'b0, 32'd0);
    send(4, 0, 1, 2, 0, 32'd3, 0, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("rej_out_valid", 32'(out_valid), 32'd0);
    check("rej_err_count", 32'(err_count), 32'd2);
    check("rej_err_sticky", 32'(err_sticky), 32'd1);
    do_clr();
    check("clr_err_count", 32'(err_count), 32'd0);
    check("clr_err_sticky", 32'(err_sticky), 32'd0);

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(9 + (i % 7), 0, 0, 0, 0, 32'd0, 0, 1'b0, 32'd0);
    check("sat_err_count", 32'(err_count), 32'hFF);
    do_clr();

    // Asynchronous reset with two words queued
    fixed_ready = 1'b0;
    send(0, 3, 7, 8, 9, 32'd0, 0, 1'b0, 32'd0);
    send(2, 2, 1, 0, 4, 32'h0000_0123, 0, 1'b0, 32'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    q.delete();
    push_count = 0;
    err_model  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_rel_out_addr", out_addr, BASE);
    check("arst_rel_in_ready", 32'(in_ready), 32'd1);
    check("arst_rel_out_valid", 32'(out_valid), 32'd0);

    // Randomized tuples with random consumer backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] imm;
      k   = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      imm = $urandom;
      if (k == 4 || k == 5) imm[0] = ($urandom_range(0, 3) == 0);
      send(k, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm, $urandom_range(0, 1), 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_ready = 1'b0;
    fixed_ready = 1'b1;
    wait_drain();
    check("rand_err_count", 32'(err_count), 32'(err_model));
    check("rand_err_sticky", 32'(err_sticky), 32'(err_model != 0));
  endtask

  initial begin
    checks = 0; errors = 0; emitted = 0; push_count = 0; err_model = 0;
    rnd_bit = 1'b0;
    fork
      monitor();
      forever begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
      end
      stimulus();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
